// File: rtl/irq_ctrl.sv
// Prioritised, nesting interrupt controller: edge-latched pending lines, programmable mask,
// preemption by strictly higher-priority channels, bounded nesting depth, sticky misuse flags.
module irq_ctrl #(
   parameter int unsigned N_IRQ      = 8,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned VEC_BASE   = 'h3C0,
   parameter int unsigned VEC_STRIDE = 4,
   parameter int unsigned NEST_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [N_IRQ-1:0]                  irq_in,
   input  logic                              ie_global,
   input  logic                              mask_we,
   input  logic [N_IRQ-1:0]                  mask_wd,
   input  logic                              ack,
   input  logic                              reti,
   input  logic                              err_clr,
   output logic                              irq_req,
   output logic [$clog2(N_IRQ)-1:0]          irq_id,
   output logic [ADDR_W-1:0]                 irq_vec,
   output logic [N_IRQ-1:0]                  pending,
   output logic [N_IRQ-1:0]                  active,
   output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_level,
   output logic [1:0]                        err
);

   localparam int unsigned ID_W = $clog2(N_IRQ);
   localparam int unsigned NL_W = $clog2(NEST_DEPTH + 1);
   localparam logic [NL_W-1:0] DEPTH_MAX = NL_W'(NEST_DEPTH);

   logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
   logic [N_IRQ-1:0] pending_q, pending_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] active_q, active_d;
   logic [NL_W-1:0]  nest_q, nest_d;
   logic [1:0]       err_q, err_d;

   logic [N_IRQ-1:0] cand;
   logic [ID_W-1:0]  winner, cur_lvl;
   logic             win_found, cur_found;
   logic             take, ret_ok;

   // Two lowest-index-first priority encoders: request candidates and in-service level.
   always_comb begin
      cand      = pending_q & mask_q;
      winner    = '0;
      win_found = 1'b0;
      cur_lvl   = '0;
      cur_found = 1'b0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         if (cand[i] && !win_found) begin
            win_found = 1'b1;
            winner    = ID_W'(i);
         end
         if (active_q[i] && !cur_found) begin
            cur_found = 1'b1;
            cur_lvl   = ID_W'(i);
         end
      end
   end

   always_comb begin
      irq_req = ie_global && win_found && (nest_q < DEPTH_MAX) &&
                (!cur_found || (winner < cur_lvl));
      irq_id  = irq_req ? winner : '0;
      irq_vec = irq_req ? (ADDR_W'(VEC_BASE) + ADDR_W'(irq_id) * ADDR_W'(VEC_STRIDE)) : '0;
   end

   always_comb begin
      take       = ack && irq_req;
      ret_ok     = reti && cur_found;
      irq_prev_d = irq_in;
      mask_d     = mask_we ? mask_wd : mask_q;

      pending_d = pending_q;
      if (take) pending_d[irq_id] = 1'b0;
      // A fresh edge is applied after the ack clear so that it survives a same-cycle ack.
      pending_d = pending_d | (irq_in & ~irq_prev_q);

      active_d = active_q;
      if (ret_ok) active_d[cur_lvl] = 1'b0;
      if (take)   active_d[irq_id]  = 1'b1;

      nest_d = nest_q;
      if (take)   nest_d = nest_d + NL_W'(1);
      if (ret_ok) nest_d = nest_d - NL_W'(1);

      err_d = err_clr ? 2'b00 : err_q;
      if (ack && !irq_req) err_d[0] = 1'b1;
      if (reti && !cur_found) err_d[1] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_prev_q <= '0;
         pending_q  <= '0;
         mask_q     <= '0;
         active_q   <= '0;
         nest_q     <= '0;
         err_q      <= '0;
      end else begin
         irq_prev_q <= irq_prev_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         active_q   <= active_d;
         nest_q     <= nest_d;
         err_q      <= err_d;
      end
   end

   assign pending    = pending_q;
   assign active     = active_q;
   assign nest_level = nest_q;
   assign err        = err_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (8 channels, nesting depth 2) with hand-computed expectations.
module tb_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] irq_in;
   logic       ie_global, mask_we, ack, reti, err_clr;
   logic [7:0] mask_wd;
   logic       irq_req;
   logic [2:0] irq_id;
   logic [9:0] irq_vec;
   logic [7:0] pending, active;
   logic [1:0] nest_level;
   logic [1:0] err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   irq_ctrl #(
      .N_IRQ      (8),
      .ADDR_W     (10),
      .VEC_BASE   ('h3C0),
      .VEC_STRIDE (4),
      .NEST_DEPTH (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .ie_global  (ie_global),
      .mask_we    (mask_we),
      .mask_wd    (mask_wd),
      .ack        (ack),
      .reti       (reti),
      .err_clr    (err_clr),
      .irq_req    (irq_req),
      .irq_id     (irq_id),
      .irq_vec    (irq_vec),
      .pending    (pending),
      .active     (active),
      .nest_level (nest_level),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] lines);
      irq_in = lines;
      tick();
      irq_in = '0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic do_reti();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic write_mask(input logic [7:0] m);
      mask_we = 1'b1;
      mask_wd = m;
      tick();
      mask_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1; irq_in = '0; ie_global = 1'b0; mask_we = 1'b0; mask_wd = '0;
      ack = 1'b0; reti = 1'b0; err_clr = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();

      check("rst_req", 32'(irq_req), 0);
      check("rst_id", 32'(irq_id), 0);
      check("rst_vec", 32'(irq_vec), 0);
      check("rst_pend", 32'(pending), 0);
      check("rst_act", 32'(active), 0);
      check("rst_nest", 32'(nest_level), 0);
      check("rst_err", 32'(err), 0);

      // Basic request/ack/reti on channel 3
      write_mask(8'hFF);
      ie_global = 1'b1;
      pulse(8'h08);
      check("b_pend", 32'(pending), 32'h08);
      check("b_req", 32'(irq_req), 1);
      check("b_id", 32'(irq_id), 3);
      check("b_vec", 32'(irq_vec), 32'h3CC);
      do_ack();
      check("b_ack_pend", 32'(pending), 0);
      check("b_ack_act", 32'(active), 32'h08);
      check("b_ack_nest", 32'(nest_level), 1);
      check("b_ack_req", 32'(irq_req), 0);
      do_reti();
      check("b_reti_act", 32'(active), 0);
      check("b_reti_nest", 32'(nest_level), 0);

      // Preemption: 3 active, 1 and 5 arrive together
      pulse(8'h08);
      do_ack();
      pulse(8'h22);
      check("p_pend", 32'(pending), 32'h22);
      check("p_req", 32'(irq_req), 1);
      check("p_id", 32'(irq_id), 1);
      check("p_vec", 32'(irq_vec), 32'h3C4);
      do_ack();
      check("p_act", 32'(active), 32'h0A);
      check("p_nest", 32'(nest_level), 2);
      check("p_req5a", 32'(irq_req), 0);
      do_reti();
      check("p_act2", 32'(active), 32'h08);
      check("p_req5b", 32'(irq_req), 0);
      do_reti();
      check("p_act3", 32'(active), 0);
      check("p_req5c", 32'(irq_req), 1);
      check("p_id5", 32'(irq_id), 5);
      check("p_vec5", 32'(irq_vec), 32'h3D4);
      do_ack();
      do_reti();
      check("p_err", 32'(err), 0);

      // Mask and global enable
      write_mask(8'hFE);
      pulse(8'h01);
      check("m_pend", 32'(pending), 32'h01);
      check("m_req_masked", 32'(irq_req), 0);
      mask_we = 1'b1; mask_wd = 8'hFF;
      #1;
      check("m_req_prewrite", 32'(irq_req), 0);
      tick();
      mask_we = 1'b0;
      check("m_req_unmasked", 32'(irq_req), 1);
      check("m_id", 32'(irq_id), 0);
      check("m_vec", 32'(irq_vec), 32'h3C0);
      ie_global = 1'b0;
      #1;
      check("m_ie_req", 32'(irq_req), 0);
      ie_global = 1'b1;
      #1;
      do_ack();
      do_reti();
      check("m_act", 32'(active), 0);

      // Depth limit: 6 then 4 nested, 0 must wait for a reti
      pulse(8'h40);
      check("d_id6", 32'(irq_id), 6);
      do_ack();
      pulse(8'h10);
      check("d_id4", 32'(irq_id), 4);
      do_ack();
      check("d_act", 32'(active), 32'h50);
      check("d_nest", 32'(nest_level), 2);
      pulse(8'h01);
      check("d_pend", 32'(pending), 32'h01);
      check("d_req_full", 32'(irq_req), 0);
      tick();
      check("d_req_full2", 32'(irq_req), 0);
      do_reti();
      check("d_act_r", 32'(active), 32'h40);
      check("d_req_after", 32'(irq_req), 1);
      check("d_id0", 32'(irq_id), 0);
      do_ack();
      check("d_act2", 32'(active), 32'h41);
      do_reti();
      do_reti();
      check("d_act_end", 32'(active), 0);
      check("d_nest_end", 32'(nest_level), 0);

      // Error flags
      do_ack();
      check("e_ack", 32'(err), 32'h1);
      check("e_ack_act", 32'(active), 0);
      do_reti();
      check("e_reti", 32'(err), 32'h3);
      check("e_reti_nest", 32'(nest_level), 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("e_clr", 32'(err), 0);
      err_clr = 1'b1; ack = 1'b1; tick(); err_clr = 1'b0; ack = 1'b0;
      check("e_clr_set", 32'(err), 32'h1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;

      // Edge on 2 in the same cycle as ack of 2
      pulse(8'h04);
      tick();
      irq_in = 8'h04; ack = 1'b1;
      tick();
      irq_in = '0; ack = 1'b0;
      check("c_pend", 32'(pending), 32'h04);
      check("c_act", 32'(active), 32'h04);
      check("c_req", 32'(irq_req), 0);
      do_reti();
      check("c_req2", 32'(irq_req), 1);
      check("c_id2", 32'(irq_id), 2);

      // ack + reti together: 2 retires, 1 enters, depth unchanged
      do_ack();
      pulse(8'h02);
      check("s_id", 32'(irq_id), 1);
      ack = 1'b1; reti = 1'b1;
      tick();
      ack = 1'b0; reti = 1'b0;
      check("s_act", 32'(active), 32'h02);
      check("s_nest", 32'(nest_level), 1);
      check("s_pend", 32'(pending), 0);
      check("s_err", 32'(err), 0);

      // Asynchronous reset mid-handler with pending = 05, active = 02
      pulse(8'h05);
      check("r_pend_pre", 32'(pending), 32'h05);
      check("r_act_pre", 32'(active), 32'h02);
      check("r_req_pre", 32'(irq_req), 1);
      #2;
      reset = 1'b1;
      #1;
      check("r_req", 32'(irq_req), 0);
      check("r_id", 32'(irq_id), 0);
      check("r_vec", 32'(irq_vec), 0);
      check("r_pend", 32'(pending), 0);
      check("r_act", 32'(active), 0);
      check("r_nest", 32'(nest_level), 0);
      check("r_err", 32'(err), 0);
      tick();
      reset = 1'b0;
      tick();
      check("r_req_post", 32'(irq_req), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
